fixed_point_alu: RTL and testbench
==================================

# fixed_point_alu

- Parametrised, handshaked fixed-point arithmetic unit: signed add, subtract, multiply and unsigned square root on Q(WIDTH−FBITS).FBITS operands.
- Sits beside the integer ALU in the execute stage.
- The pipeline asserts `start` for one cycle and waits for the `result_valid` pulse. The unit holds the result and an overflow flag until the next operation completes.
- Multiply is sequential over MUL_CHUNK-wide partial products. Square root is radix-2 restoring.

## Interface
- WIDTH, 32: operand/result width; must be a multiple of MUL_CHUNK.
- FBITS, 10: fractional bits; WIDTH+FBITS must be even.
- MUL_CHUNK, 16: partial-product width per multiply cycle.
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request; sampled only while busy=0.
- operation  in  2  00 ADD, 01 SUB, 10 MUL, 11 SQRT; captured with start.
- operand_1  in  WIDTH  signed Q operand A (SQRT: radicand).
- operand_2  in  WIDTH  signed Q operand B (ignored for SQRT); captured with start.
- busy  out  1  multi-cycle operation in progress.
- result_valid  out  1  one-cycle completion pulse.
- result  out  WIDTH  last completed result, held.
- overflow  out  1  overflow/invalid flag of last result, held.

## Operation
- Reset: busy=0, result_valid=0, result=0, overflow=0, FSM=IDLE, all datapath registers cleared.
- Reset mid-operation aborts with no result_valid.
- FSM states:
  - IDLE. start with ADD/SUB: compute and register the result, stay in IDLE. start with MUL → MUL_ITER. start with SQRT → SQRT_ITER.
  - MUL_ITER: N=(WIDTH/MUL_CHUNK)² steps → FINISH.
  - SQRT_ITER: ITER=(WIDTH+FBITS)/2 steps → FINISH.
  - FINISH: load result/overflow, pulse result_valid → IDLE.
- ADD/SUB:
  - Two's-complement WIDTH-bit sum/difference.
  - overflow = signed overflow (operand signs agree and result sign differs; for SUB, compare against the negated B).
- MUL:
  - Magnitudes of A and B are multiplied chunk by chunk, one MUL_CHUNK×MUL_CHUNK partial product per cycle, accumulated into a 2·WIDTH register.
  - Sign = signA^signB.
  - Take magnitude bits [WIDTH+FBITS−1:FBITS] (truncation toward zero), then negate if the sign is negative.
  - overflow=1 if any discarded high magnitude bit is set, or the signed result does not fit in WIDTH.
  - The most-negative operand is handled as a magnitude of 2^(WIDTH−1).
- SQRT:
  - result = floor(sqrt(operand_1·2^FBITS)), i.e. the Q root.
  - One bit per cycle using the restoring test ac − {q,01}.
  - Negative operand_1: result=0, overflow=1, same latency.
- Operands are registered on start; input changes during busy have no effect.
- start while busy=1 is ignored (no queueing).
- Undefined operation encodings do not exist (2 bits fully decoded).

## Timing
- start accepted at edge T.
- ADD/SUB: result_valid=1 during cycle T+1; busy never asserts.
- MUL: busy=1 from T+1 through T+N; result_valid during T+N+1, with busy=0 in that cycle. WIDTH=32, MUL_CHUNK=16 gives N=4, latency 5.
- SQRT: same pattern with ITER. WIDTH=32, FBITS=10 gives ITER=21, latency 22.
- result/overflow update in the same cycle result_valid rises and are stable until the next result_valid.
- A new start is accepted in the result_valid cycle (busy=0), which gives back-to-back operation.

## Configuration
- FXP_SATURATE_EN defined:
  - ADD/SUB/MUL results that overflow clamp to 2^(WIDTH−1)−1 (positive) or −2^(WIDTH−1) (negative).
  - overflow is still set.
- FXP_SATURATE_EN undefined: overflowing results wrap (truncated WIDTH bits); overflow is still set.
- SQRT behaviour is identical in both builds.

## Test plan
- ADD 0x00000C00 (3.0) + 0x00000400 (1.0) → result 0x00001000, overflow=0, result_valid at T+1, busy stays 0.
- MUL 0x00000600 (1.5) × 0xFFFFF800 (−2.0) → 0xFFFFF400 (−3.0), busy high 4 cycles, result_valid at T+5.
- SQRT 0x00001000 (4.0) → 0x00000800 (2.0) at T+22. SQRT 0x80000000 → result 0, overflow=1.
- ADD 0x7FFFFFFF + 0x00000001:
  - With FXP_SATURATE_EN → 0x7FFFFFFF, overflow=1.
  - Without → 0x80000000, overflow=1.
- MUL 0x7FFFFFFF × 0x00000800 (2.0): overflow=1. Result 0x7FFFFFFF when saturating; truncated magnitude bits otherwise.
- Start SQRT, pulse start with ADD at T+3 (ignored), assert reset at T+10:
  - busy=0, result=0, no result_valid.
  - A subsequent ADD completes normally at its T+1.

Source files
------------

// File: rtl/fixed_point_alu.sv
// Handshaked Q-format ALU: signed add/sub (single cycle), chunked sequential multiply and
// radix-2 restoring square root. Define FXP_SATURATE_EN to clamp overflowing ADD/SUB/MUL results.
module fixed_point_alu #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned FBITS     = 10,
    parameter int unsigned MUL_CHUNK = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       operation,
    input  logic [WIDTH-1:0] operand_1,
    input  logic [WIDTH-1:0] operand_2,
    output logic             busy,
    output logic             result_valid,
    output logic [WIDTH-1:0] result,
    output logic             overflow
);

    localparam int unsigned NC      = WIDTH / MUL_CHUNK;
    localparam int unsigned N_MUL   = NC * NC;
    localparam int unsigned XW      = WIDTH + FBITS;
    localparam int unsigned ITER    = XW / 2;
    localparam int unsigned RW      = ITER + 2;
    localparam int unsigned CNT_MAX = (N_MUL > ITER) ? N_MUL : ITER;
    localparam int unsigned CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int unsigned CIW     = (NC > 1) ? $clog2(NC) : 1;

    localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    localparam logic [1:0] OpAdd  = 2'b00;
    localparam logic [1:0] OpSub  = 2'b01;
    localparam logic [1:0] OpMul  = 2'b10;
    localparam logic [1:0] OpSqrt = 2'b11;

    typedef enum logic [1:0] {StIdle, StMulIter, StSqrtIter, StFinish} state_t;

    state_t               state_q;
    logic [CW-1:0]        cnt_q;
    logic [CIW-1:0]       ci_q, cj_q;
    logic [WIDTH-1:0]     mag_a_q, mag_b_q;
    logic                 neg_q;
    logic [2*WIDTH-1:0]   acc_q;
    logic [XW-1:0]        x_q;
    logic [RW-1:0]        rem_q;
    logic [ITER-1:0]      root_q;

    // Add / subtract, evaluated directly from the inputs at start
    logic             a_sign, b_sign;
    logic [WIDTH-1:0] as_raw, as_res;
    logic             as_ovf;
    logic [WIDTH-1:0] mag_a_in, mag_b_in;

    always_comb begin
        a_sign = operand_1[WIDTH-1];
        b_sign = operand_2[WIDTH-1];
        if (operation == OpSub) begin
            as_raw = operand_1 - operand_2;
            as_ovf = (a_sign != b_sign) && (as_raw[WIDTH-1] != a_sign);
        end else begin
            as_raw = operand_1 + operand_2;
            as_ovf = (a_sign == b_sign) && (as_raw[WIDTH-1] != a_sign);
        end
        as_res = as_raw;
`ifdef FXP_SATURATE_EN
        if (as_ovf) as_res = a_sign ? MIN_NEG : MAX_POS;
`endif
        // Negating the most-negative value yields 2^(WIDTH-1) read as unsigned
        mag_a_in = a_sign ? (~operand_1 + 1'b1) : operand_1;
        mag_b_in = b_sign ? (~operand_2 + 1'b1) : operand_2;
    end

    // Multiply step and final rounding/sign handling
    logic [MUL_CHUNK-1:0]   a_chunk, b_chunk;
    logic [2*MUL_CHUNK-1:0] pp;
    int unsigned            shamt;
    logic [2*WIDTH-1:0]     acc_next;
    logic [WIDTH-1:0]       mul_mag, mul_raw, mul_res;
    logic                   mul_ovf;

    always_comb begin
        a_chunk  = mag_a_q[32'(ci_q) * MUL_CHUNK +: MUL_CHUNK];
        b_chunk  = mag_b_q[32'(cj_q) * MUL_CHUNK +: MUL_CHUNK];
        pp       = {{MUL_CHUNK{1'b0}}, a_chunk} * {{MUL_CHUNK{1'b0}}, b_chunk};
        shamt    = (32'(ci_q) + 32'(cj_q)) * MUL_CHUNK;
        acc_next = acc_q + ((2*WIDTH)'(pp) << shamt);
        mul_mag  = acc_next[XW-1:FBITS];
        mul_ovf  = (|acc_next[2*WIDTH-1:XW]) ||
                   (neg_q ? (mul_mag > MIN_NEG) : mul_mag[WIDTH-1]);
        mul_raw  = neg_q ? (~mul_mag + 1'b1) : mul_mag;
        mul_res  = mul_raw;
`ifdef FXP_SATURATE_EN
        if (mul_ovf) mul_res = neg_q ? MIN_NEG : MAX_POS;
`endif
    end

    // Restoring square root: one root bit per step from the top two radicand bits
    logic [RW-1:0]   ac, rem_next;
    logic [RW:0]     trial;
    logic            trial_ge;
    logic [ITER-1:0] root_next;

    always_comb begin
        ac        = {rem_q[RW-3:0], x_q[XW-1 -: 2]};
        trial     = {1'b0, ac} - {1'b0, root_q, 2'b01};
        trial_ge  = ~trial[RW];
        rem_next  = trial_ge ? trial[RW-1:0] : ac;
        root_next = {root_q[ITER-2:0], trial_ge};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            ci_q         <= '0;
            cj_q         <= '0;
            mag_a_q      <= '0;
            mag_b_q      <= '0;
            neg_q        <= 1'b0;
            acc_q        <= '0;
            x_q          <= '0;
            rem_q        <= '0;
            root_q       <= '0;
            busy         <= 1'b0;
            result_valid <= 1'b0;
            result       <= '0;
            overflow     <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle, StFinish: begin
                    result_valid <= 1'b0;
                    state_q      <= StIdle;
                    if (start) begin
                        unique case (operation)
                            OpAdd, OpSub: begin
                                result       <= as_res;
                                overflow     <= as_ovf;
                                result_valid <= 1'b1;
                            end
                            OpMul: begin
                                mag_a_q <= mag_a_in;
                                mag_b_q <= mag_b_in;
                                neg_q   <= a_sign ^ b_sign;
                                acc_q   <= '0;
                                ci_q    <= '0;
                                cj_q    <= '0;
                                cnt_q   <= '0;
                                busy    <= 1'b1;
                                state_q <= StMulIter;
                            end
                            OpSqrt: begin
                                x_q     <= a_sign ? '0 : (XW'(operand_1) << FBITS);
                                neg_q   <= a_sign;
                                rem_q   <= '0;
                                root_q  <= '0;
                                cnt_q   <= '0;
                                busy    <= 1'b1;
                                state_q <= StSqrtIter;
                            end
                        endcase
                    end
                end
                StMulIter: begin
                    acc_q <= acc_next;
                    cnt_q <= cnt_q + 1'b1;
                    if (cj_q == CIW'(NC - 1)) begin
                        cj_q <= '0;
                        ci_q <= ci_q + 1'b1;
                    end else begin
                        cj_q <= cj_q + 1'b1;
                    end
                    if (cnt_q == CW'(N_MUL - 1)) begin
                        result       <= mul_res;
                        overflow     <= mul_ovf;
                        result_valid <= 1'b1;
                        busy         <= 1'b0;
                        state_q      <= StFinish;
                    end
                end
                StSqrtIter: begin
                    x_q    <= x_q << 2;
                    rem_q  <= rem_next;
                    root_q <= root_next;
                    cnt_q  <= cnt_q + 1'b1;
                    if (cnt_q == CW'(ITER - 1)) begin
                        result       <= neg_q ? '0 : WIDTH'(root_next);
                        overflow     <= neg_q;
                        result_valid <= 1'b1;
                        busy         <= 1'b0;
                        state_q      <= StFinish;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fixed_point_alu.sv
// Directed-vector bench for fixed_point_alu (WIDTH=32, FBITS=10, MUL_CHUNK=16).
module tb_fixed_point_alu;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  operation;
    logic [31:0] operand_1, operand_2;
    logic        busy, result_valid, overflow;
    logic [31:0] result;

    int checks   = 0;
    int failures = 0;

    localparam logic [1:0] ADD = 2'b00, SUB = 2'b01, MUL = 2'b10, SQRT = 2'b11;

`ifdef FXP_SATURATE_EN
    localparam logic [31:0] ADD_OVF_RES = 32'h7FFFFFFF;
    localparam logic [31:0] SUB_OVF_RES = 32'h80000000;
    localparam logic [31:0] MUL_OVF_RES = 32'h7FFFFFFF;
`else
    localparam logic [31:0] ADD_OVF_RES = 32'h80000000;
    localparam logic [31:0] SUB_OVF_RES = 32'h7FFFFFFF;
    localparam logic [31:0] MUL_OVF_RES = 32'hFFFFFFFE;
`endif

    fixed_point_alu #(.WIDTH(32), .FBITS(10), .MUL_CHUNK(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .operation    (operation),
        .operand_1    (operand_1),
        .operand_2    (operand_2),
        .busy         (busy),
        .result_valid (result_valid),
        .result       (result),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        ovf;
        int          lat;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        start     = 1'b1;
        operation = op;
        operand_1 = a;
        operand_2 = b;
    endtask

    // Returns cycles from accept edge to result_valid and how many of those had busy=1
    task automatic wait_done(output int lat, output int busy_cycles);
        @(posedge clk);
        #1;
        start     = 1'b0;
        operation = ADD;
        operand_1 = 32'hDEADBEEF;
        operand_2 = 32'h12345678;
        lat         = 1;
        busy_cycles = 0;
        while (!result_valid && lat < 100) begin
            if (busy) busy_cycles++;
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    initial begin
        int lat, bc, pulses;
        vecs[0]  = '{"add_basic",    ADD,  32'h00000C00, 32'h00000400, 32'h00001000, 1'b0, 1};
        vecs[1]  = '{"sub_basic",    SUB,  32'h00001000, 32'h00000400, 32'h00000C00, 1'b0, 1};
        vecs[2]  = '{"mul_pos_neg",  MUL,  32'h00000600, 32'hFFFFF800, 32'hFFFFF400, 1'b0, 5};
        vecs[3]  = '{"sqrt_4",       SQRT, 32'h00001000, 32'h0,        32'h00000800, 1'b0, 22};
        vecs[4]  = '{"sqrt_neg",     SQRT, 32'h80000000, 32'h0,        32'h00000000, 1'b1, 22};
        vecs[5]  = '{"add_ovf",      ADD,  32'h7FFFFFFF, 32'h00000001, ADD_OVF_RES,  1'b1, 1};
        vecs[6]  = '{"mul_ovf",      MUL,  32'h7FFFFFFF, 32'h00000800, MUL_OVF_RES,  1'b1, 5};
        vecs[7]  = '{"sub_ovf",      SUB,  32'h80000000, 32'h00000001, SUB_OVF_RES,  1'b1, 1};
        vecs[8]  = '{"mul_minneg",   MUL,  32'h80000000, 32'h00000400, 32'h80000000, 1'b0, 5};
        vecs[9]  = '{"sqrt_1",       SQRT, 32'h00000400, 32'h0,        32'h00000400, 1'b0, 22};
        vecs[10] = '{"sqrt_2",       SQRT, 32'h00000800, 32'h0,        32'h000005A8, 1'b0, 22};
        vecs[11] = '{"mul_neg_neg",  MUL,  32'hFFFFFC00, 32'hFFFFFA00, 32'h00000600, 1'b0, 5};
        vecs[12] = '{"mul_hi_chunk", MUL,  32'h00010000, 32'h00010000, 32'h00400000, 1'b0, 5};
        vecs[13] = '{"mul_mixed",    MUL,  32'h00018000, 32'h00000400, 32'h00018000, 1'b0, 5};
        vecs[14] = '{"sqrt_max",     SQRT, 32'h7FFFFFFF, 32'h0,        32'h0016A09E, 1'b0, 22};

        reset = 1'b1; start = 1'b0; operation = ADD; operand_1 = '0; operand_2 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy",  {31'd0, busy},         32'd0);
        check("reset_valid", {31'd0, result_valid}, 32'd0);
        check("reset_res",   result,                32'd0);
        check("reset_ovf",   {31'd0, overflow},     32'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            issue(vecs[i].op, vecs[i].a, vecs[i].b);
            wait_done(lat, bc);
            check({vecs[i].name, "_res"}, result, vecs[i].res);
            check({vecs[i].name, "_ovf"}, {31'd0, overflow}, {31'd0, vecs[i].ovf});
            check({vecs[i].name, "_lat"}, lat, vecs[i].lat);
            check({vecs[i].name, "_busy_cycles"}, bc, vecs[i].lat - 1);
            check({vecs[i].name, "_busy_at_valid"}, {31'd0, busy}, 32'd0);
            @(posedge clk);
            #1;
            check({vecs[i].name, "_pulse_end"}, {31'd0, result_valid}, 32'd0);
            check({vecs[i].name, "_hold"}, result, vecs[i].res);
        end

        // Back-to-back: ADD issued in the MUL result_valid cycle
        @(negedge clk);
        issue(MUL, 32'h00000600, 32'h00000800);
        wait_done(lat, bc);
        check("b2b_mul_res", result, 32'h00000C00);
        issue(ADD, 32'h00000100, 32'h00000200);
        wait_done(lat, bc);
        check("b2b_add_lat", lat, 1);
        check("b2b_add_res", result, 32'h00000300);

        // SQRT aborted by reset, with an ignored start in between
        @(negedge clk);
        issue(SQRT, 32'h00001000, 32'h0);
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        issue(ADD, 32'h00000001, 32'h00000001);
        @(posedge clk);
        #1;
        start = 1'b0;
        check("ignored_start_valid", {31'd0, result_valid}, 32'd0);
        check("ignored_start_busy",  {31'd0, busy},         32'd1);
        check("ignored_start_res",   result,                32'h00000300);
        repeat (6) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort_busy",  {31'd0, busy},         32'd0);
        check("abort_res",   result,                32'd0);
        check("abort_valid", {31'd0, result_valid}, 32'd0);
        @(negedge clk);
        reset  = 1'b0;
        pulses = 0;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk);
            #1;
            if (result_valid) pulses++;
        end
        check("abort_no_valid", pulses, 0);
        @(negedge clk);
        issue(ADD, 32'h00000400, 32'h00000400);
        wait_done(lat, bc);
        check("post_abort_lat", lat, 1);
        check("post_abort_res", result, 32'h00000800);
        check("post_abort_ovf", {31'd0, overflow}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
